// File: rtl/seq_div16by8_pkg.sv
// Shared definitions for the sequential 16/8 restoring divider.
package seq_div16by8_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;

  // Width of an iteration counter that must hold the value w-1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/seq_div16by8_if.sv
// Operand/result handshake bundle for the sequential divider.
interface seq_div16by8_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div16by8_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_div16by8_div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W-1:0] partial_rem,
  input  logic                 in_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] next_rem,
  output logic                 qbit
);

  logic [DIVISOR_W:0] trial;

  // The stored remainder is always below the divisor, so its extra top bit is
  // zero and only the low bits are carried between steps. When the trial value
  // is at least the divisor the difference fits in DIVISOR_W bits, so the
  // modulo subtraction on the low bits is exact.
  always_comb begin
    trial = {partial_rem, in_bit};
    qbit  = (trial >= {1'b0, divisor});
    if (qbit) begin
      next_rem = trial[DIVISOR_W-1:0] - divisor;
    end else begin
      next_rem = trial[DIVISOR_W-1:0];
    end
  end

endmodule

// File: rtl/seq_div16by8.sv
// Sequential radix-2 restoring divider: one quotient bit per clock,
// valid/ready handshake on operands and result, zero-divisor flagged.
module seq_div16by8
  import seq_div16by8_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_div16by8_if.slave bus
);

  localparam int CW = cnt_w(DIVIDEND_W);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] shift_reg;
  logic [DIVISOR_W-1:0]  partial_rem;
  logic [DIVISOR_W-1:0]  divisor_hold;
  logic                  in_ready;
  logic                  out_valid;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_qbit;

  seq_div16by8_div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .partial_rem(partial_rem),
    .in_bit     (shift_reg[DIVIDEND_W-1]),
    .divisor    (divisor_hold),
    .next_rem   (step_rem),
    .qbit       (step_qbit)
  );

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;

  // Control FSM and datapath; all handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shift_reg    <= '0;
      partial_rem  <= '0;
      divisor_hold <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            shift_reg    <= bus.dividend;
            divisor_hold <= bus.divisor;
            partial_rem  <= '0;
            cnt          <= CW'(DIVIDEND_W - 1);
            in_ready     <= 1'b0;
            if (bus.divisor == '0) begin
              // Zero divisor skips the iteration and reports a saturated quotient.
              quotient    <= '1;
              remainder   <= bus.dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          partial_rem <= step_rem;
          shift_reg   <= {shift_reg[DIVIDEND_W-2:0], step_qbit};
          if (cnt == '0) begin
            // Final step: publish the result directly from the step outputs.
            quotient  <= {shift_reg[DIVIDEND_W-2:0], step_qbit};
            remainder <= step_rem;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_div16by8.md
Name: seq_div16by8

Overview:
- Sequential radix-2 restoring divider. It is the inverse companion of the team's 8x8 Wallace multiplier.
- Divides a 16-bit unsigned dividend (product width) by an 8-bit unsigned divisor, producing a 16-bit quotient and an 8-bit remainder.
- Resolves one quotient bit per clock and uses a valid/ready handshake on both input and output.
- Sits beside the multiplier in the arithmetic datapath; its results are checked against the multiplier.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width.
- DIVISOR_W, 8, divisor and remainder width; must be less than or equal to DIVIDEND_W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand pair is presented.
- in_ready  output  1  block accepts an operand pair this cycle.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- out_valid  output  1  result is presented.
- out_ready  input  1  consumer accepts the result.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values, applied immediately on rst_n low regardless of clk:
  - state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal iteration counter=0, partial remainder=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch dividend into the quotient/shift register and divisor into a holding register. Clear the partial remainder (DIVISOR_W+1 bits) and set counter=DIVIDEND_W-1.
  - If divisor==0: go to DONE with quotient=all ones, remainder=dividend[DIVISOR_W-1:0], div_by_zero=1.
  - Otherwise go to CALC with div_by_zero=0.
- CALC (in_ready=0, out_valid=0), one step per cycle:
  - r = {partial_rem[DIVISOR_W-1:0], shift_reg MSB}.
  - If r >= {1'b0,divisor}: partial_rem = r - divisor, qbit=1. Else partial_rem = r, qbit=0.
  - shift_reg = {shift_reg[DIVIDEND_W-2:0], qbit}.
  - When counter==0, go to DONE; otherwise decrement counter.
  - Exactly DIVIDEND_W (16) CALC cycles.
- DONE:
  - out_valid=1.
  - quotient=shift_reg; remainder=partial_rem[DIVISOR_W-1:0] (bit DIVISOR_W is always 0 after the final step).
  - Outputs stay stable while out_valid && !out_ready.
  - On out_valid&&out_ready, go to IDLE; out_valid deasserts on the next cycle.
- Latency:
  - Accept edge at cycle 0; out_valid is high from cycle DIVIDEND_W+1 (17).
  - Divide-by-zero: out_valid from cycle 1.
  - Throughput: one operation per DIVIDEND_W+2 cycles when out_ready is held high.
- in_valid while not in IDLE is ignored; the operand is not queued and the upstream must hold it.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Reset mid-operation: aborts at once, outputs return to reset values, and no result is emitted.
- Arithmetic invariant for nonzero divisor: dividend == quotient*divisor + remainder, with remainder < divisor.
- Boundary inputs:
  - dividend=0 gives quotient 0, remainder 0.
  - divisor=1 gives quotient=dividend, remainder 0.
  - divisor > dividend gives quotient 0, remainder=dividend.

Decomposition:
- Shared package (arith_pkg): DIVIDEND_W/DIVISOR_W defaults, the state enum {IDLE,CALC,DONE}, and the counter width localparam $clog2(DIVIDEND_W).
- One natural sub-module: div_step. It is purely combinational: inputs partial_rem, incoming bit and divisor; outputs next partial_rem and qbit. It is instantiated once inside the CALC datapath.

Test Plan:
- 0x03E8 / 0x07 with out_ready=1 -> quotient 0x008E, remainder 0x06, div_by_zero 0, out_valid rises exactly 17 cycles after accept.
- 0xFFFF / 0xFF -> quotient 0x0101, remainder 0x00. Also 0x1234 / 0x01 -> quotient 0x1234, remainder 0x00.
- 0x00AB / 0x00 -> out_valid 1 cycle after accept, quotient 0xFFFF, remainder 0xAB, div_by_zero 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; pulse in_valid with new operands during CALC and during DONE -> outputs stable, in_ready=0, new operands ignored, and they are accepted only after the handshake completes and the block returns to IDLE.
- Reset mid-CALC: assert rst_n=0 at cycle 8 of 0x8000 / 0x03 -> out_valid=0 and in_ready=1 immediately. After release, 0x8000 / 0x03 -> 0x2AAA r 0x02.
- Random 10k operand pairs, back-to-back: check quotient*divisor+remainder==dividend and remainder<divisor. For quotient<256, also cross-check the reconstruction against the wallace8 product of quotient[7:0] and divisor.
